// File: rtl/fifo_ctl_dpram.sv
// fifo_ctl_dpram: single-clock FIFO controller in front of a dual-port RAM
// that has a registered read output. Port 0 of the RAM writes and port 1
// reads. The RAM read path takes 2 cycles, so a 3-entry output buffer is
// kept full by issuing reads ahead of time. This lets the FIFO sustain one
// word per cycle.
//
// Handshakes: a word moves on a side only in a cycle where both valid and
// ready are high at the clock edge. Ready never depends on the valid of the
// same side. wr_rdy is a function of registered state only. rd_vld
// and rd_dat come straight from the output buffer registers.
module fifo_ctl_dpram #(
  parameter int ADDRBIT   = 6,
  parameter int DEPTH     = 48,
  parameter int WIDTH     = 80,
  parameter int AFULL_LVL = 40
) (
  input  logic               clk,
  input  logic               rst_,
  input  logic               wr_vld,
  input  logic [WIDTH-1:0]   wr_dat,
  output logic               wr_rdy,
  output logic               rd_vld,
  output logic [WIDTH-1:0]   rd_dat,
  input  logic               rd_rdy,
  output logic [ADDRBIT:0]   count,
  output logic               afull,
  output logic               ovf,
  input  logic               clr_ovf,
  output logic [ADDRBIT-1:0] ram_wa,
  output logic               ram_we,
  output logic [WIDTH-1:0]   ram_di,
  output logic [ADDRBIT-1:0] ram_ra,
  output logic               ram_re,
  input  logic [WIDTH-1:0]   ram_do
);

  localparam int CW = ADDRBIT + 1;
  localparam logic [ADDRBIT-1:0] LAST_ADDR = ADDRBIT'(DEPTH - 1);
  localparam logic [CW-1:0]      FULL_CNT  = CW'(DEPTH);
  localparam logic [CW-1:0]      AFULL_CNT = CW'(AFULL_LVL);

  // Words sitting in the RAM array that have not been read yet.
  logic [ADDRBIT-1:0] wptr;
  logic [ADDRBIT-1:0] rptr;
  logic [CW-1:0]      ram_cnt;
  logic [CW-1:0]      ram_cnt_nxt;

  // inflight[0]: read issued last cycle. inflight[1]: its data is on ram_do now.
  logic [1:0]         inflight;
  logic [1:0]         infl_cnt;

  // Output buffer. Entry 0 is the head, and entries shift down on a pop.
  logic [WIDTH-1:0]   obuf     [3];
  logic [WIDTH-1:0]   obuf_nxt [3];
  logic [1:0]         obuf_cnt;
  logic [1:0]         obuf_cnt_nxt;
  logic [1:0]         cap_slot;

  logic               wr_acc;
  logic               rd_iss;
  logic               pop;
  logic               cap;
  logic [2:0]         credit;
  logic [CW-1:0]      count_nxt;
  logic               afull_q;
  logic               ovf_q;

  assign infl_cnt = {1'b0, inflight[0]} + {1'b0, inflight[1]};

  assign wr_rdy = (ram_cnt != FULL_CNT);
  assign wr_acc = wr_vld & wr_rdy;
  assign rd_vld = (obuf_cnt != 2'd0);
  assign pop    = rd_vld & rd_rdy;
  assign cap    = inflight[1];

  // A read may issue only when the buffer still has room for every word
  // already committed to it, counting the word that leaves this cycle.
  assign credit = {1'b0, obuf_cnt} + {1'b0, infl_cnt} - {2'b00, pop};
  assign rd_iss = (ram_cnt != '0) && (credit < 3'd3);

  assign ram_we = wr_acc;
  assign ram_wa = wptr;
  assign ram_di = wr_dat;
  assign ram_re = rd_iss;
  assign ram_ra = rptr;

  assign ram_cnt_nxt  = ram_cnt + CW'(wr_acc) - CW'(rd_iss);
  assign obuf_cnt_nxt = obuf_cnt + {1'b0, cap} - {1'b0, pop};
  assign cap_slot     = obuf_cnt - {1'b0, pop};

  assign count     = ram_cnt + CW'(infl_cnt) + CW'(obuf_cnt);
  assign count_nxt = ram_cnt_nxt + CW'(inflight[0]) + CW'(rd_iss) + CW'(obuf_cnt_nxt);

  assign rd_dat = obuf[0];
  assign afull  = afull_q;
  assign ovf    = ovf_q;

  // Next contents of the output buffer: shift on pop, then land the returning word.
  always_comb begin
    obuf_nxt[0] = obuf[0];
    obuf_nxt[1] = obuf[1];
    obuf_nxt[2] = obuf[2];
    if (pop) begin
      obuf_nxt[0] = obuf[1];
      obuf_nxt[1] = obuf[2];
    end
    if (cap) begin
      case (cap_slot)
        2'd0:    obuf_nxt[0] = ram_do;
        2'd1:    obuf_nxt[1] = ram_do;
        default: obuf_nxt[2] = ram_do;
      endcase
    end
  end

  // Pointers, RAM occupancy, read-latency pipe and buffer fill level.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      wptr     <= '0;
      rptr     <= '0;
      ram_cnt  <= '0;
      inflight <= 2'b00;
      obuf_cnt <= 2'd0;
    end else begin
      if (wr_acc) wptr <= (wptr == LAST_ADDR) ? '0 : wptr + 1'b1;
      if (rd_iss) rptr <= (rptr == LAST_ADDR) ? '0 : rptr + 1'b1;
      ram_cnt  <= ram_cnt_nxt;
      inflight <= {inflight[0], rd_iss};
      obuf_cnt <= obuf_cnt_nxt;
    end
  end

  // Output buffer data registers.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      for (int i = 0; i < 3; i++) obuf[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) obuf[i] <= obuf_nxt[i];
    end
  end

  // Almost-full follows the next occupancy. Overflow is sticky, and a new overflow beats a clear.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      afull_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      afull_q <= (count_nxt >= AFULL_CNT);
      ovf_q   <= (wr_vld & ~wr_rdy) | (ovf_q & ~clr_ovf);
    end
  end

endmodule

// File: tb/tb_fifo_ctl_dpram.sv
// Bench for fifo_ctl_dpram: includes a registered-output RAM model, a
// queue-based occupancy/ordering model checked every cycle, and directed
// sequences with literal expectations.
module tb_fifo_ctl_dpram;
  localparam int ADDRBIT   = 6;
  localparam int DEPTH     = 48;
  localparam int WIDTH     = 80;
  localparam int AFULL_LVL = 40;

  logic               clk;
  logic               rst_;
  logic               wr_vld;
  logic [WIDTH-1:0]   wr_dat;
  logic               wr_rdy;
  logic               rd_vld;
  logic [WIDTH-1:0]   rd_dat;
  logic               rd_rdy;
  logic [ADDRBIT:0]   count;
  logic               afull;
  logic               ovf;
  logic               clr_ovf;
  logic [ADDRBIT-1:0] ram_wa;
  logic               ram_we;
  logic [WIDTH-1:0]   ram_di;
  logic [ADDRBIT-1:0] ram_ra;
  logic               ram_re;
  logic [WIDTH-1:0]   ram_do;

  fifo_ctl_dpram #(
    .ADDRBIT(ADDRBIT), .DEPTH(DEPTH), .WIDTH(WIDTH), .AFULL_LVL(AFULL_LVL)
  ) dut (
    .clk(clk), .rst_(rst_),
    .wr_vld(wr_vld), .wr_dat(wr_dat), .wr_rdy(wr_rdy),
    .rd_vld(rd_vld), .rd_dat(rd_dat), .rd_rdy(rd_rdy),
    .count(count), .afull(afull), .ovf(ovf), .clr_ovf(clr_ovf),
    .ram_wa(ram_wa), .ram_we(ram_we), .ram_di(ram_di),
    .ram_ra(ram_ra), .ram_re(ram_re), .ram_do(ram_do)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- RAM model: array read, then output register ----------------
  logic [WIDTH-1:0] mem [0:(1<<ADDRBIT)-1];
  logic [WIDTH-1:0] arr_q;
  always @(posedge clk) begin
    if (ram_we) mem[ram_wa] <= ram_di;
    if (ram_re) arr_q <= mem[ram_ra];
    ram_do <= arr_q;
  end

  // ---------------- check bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // ---------------- scoreboard model ----------------
  logic [WIDTH-1:0] exp_q[$];
  int   m_cnt;
  logic m_ovf;
  int   m_wa, m_ra, m_acc, m_iss, m_pop;

  task automatic model_clear();
    exp_q.delete();
    m_cnt = 0; m_ovf = 1'b0;
    m_wa = 0; m_ra = 0; m_acc = 0; m_iss = 0; m_pop = 0;
  endtask

  initial model_clear();

  // Compare process: outputs are checked at each falling edge, and then the model advances.
  always @(negedge clk) begin
    if (!rst_) begin
      model_clear();
    end else begin
      chk("count", count, m_cnt);
      chk("afull", afull, (m_cnt >= AFULL_LVL));
      chk("ovf", ovf, m_ovf);
      chk("outstanding_le3", ((m_iss - m_pop) <= 3), 1);
      if (m_cnt < DEPTH) chk("wr_rdy_below_depth", wr_rdy, 1);
      if (m_cnt >= DEPTH + 3) chk("wr_rdy_at_max", wr_rdy, 0);
      chk("ram_we", ram_we, (wr_vld & wr_rdy));
      if (ram_we) begin
        chk("ram_wa", ram_wa, m_wa);
        chk("ram_di", ram_di, wr_dat);
      end
      if (ram_re) begin
        chk("ram_ra", ram_ra, m_ra);
        chk("read_of_written", (m_iss < m_acc), 1);
      end
      if (rd_vld) chk("rd_vld_has_data", (exp_q.size() > 0), 1);
      if (rd_vld && rd_rdy) begin
        if (exp_q.size() == 0) chk("pop_nonempty", 0, 1);
        else chk("rd_dat_order", rd_dat, exp_q.pop_front());
      end
      // advance model with this cycle's handshakes
      if (wr_vld && wr_rdy) begin
        exp_q.push_back(wr_dat);
        m_cnt++; m_acc++;
        m_wa = (m_wa == DEPTH - 1) ? 0 : m_wa + 1;
      end
      if (rd_vld && rd_rdy) begin
        m_cnt--; m_pop++;
      end
      if (ram_re) begin
        m_iss++;
        m_ra = (m_ra == DEPTH - 1) ? 0 : m_ra + 1;
      end
      if (wr_vld && !wr_rdy) m_ovf = 1'b1;
      else if (clr_ovf) m_ovf = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int budget);
    bit done;
    done = 1'b0;
    wr_vld = 1'b0;
    rd_rdy = 1'b1;
    for (int i = 0; i < budget && !done; i++) begin
      tick();
      if (count == 0 && !rd_vld) done = 1'b1;
    end
    if (!done) chk("drain_timeout", 0, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int exp_re  [6];
    int exp_vld [6];
    int exp_cnt [6];
    int acc, nw, npop, first, last;
    bit afull_seen, got;

    exp_re  = '{0, 1, 0, 0, 0, 0};
    exp_vld = '{0, 0, 0, 0, 1, 0};
    exp_cnt = '{0, 1, 1, 1, 1, 0};

    rst_ = 1'b0; wr_vld = 1'b0; wr_dat = '0; rd_rdy = 1'b0; clr_ovf = 1'b0;
    repeat (3) tick();

    // Reset values
    chk("rst_wr_rdy", wr_rdy, 1);
    chk("rst_rd_vld", rd_vld, 0);
    chk("rst_count", count, 0);
    chk("rst_afull", afull, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_ram_re", ram_re, 0);
    chk("rst_rd_dat", rd_dat, 0);
    rst_ = 1'b1;
    repeat (2) tick();

    // Single word latency: write in cycle 0, head valid in cycle 4
    for (int c = 0; c < 6; c++) begin
      if (c > 0) tick();
      wr_vld = (c == 0);
      wr_dat = 80'hA5;
      rd_rdy = 1'b1;
      @(negedge clk);
      chk("t1_ram_re", ram_re, exp_re[c]);
      chk("t1_rd_vld", rd_vld, exp_vld[c]);
      chk("t1_count", count, exp_cnt[c]);
      if (c == 0) begin
        chk("t1_ram_we", ram_we, 1);
        chk("t1_ram_wa", ram_wa, 0);
      end
      if (c == 1) chk("t1_ram_ra", ram_ra, 0);
      if (c == 4) chk("t1_rd_dat", rd_dat, 80'hA5);
    end

    // Fill with the reader stalled: 48 in RAM + 3 in the buffer
    acc = 0; afull_seen = 1'b0;
    for (int c = 0; c < 60; c++) begin
      tick();
      rd_rdy = 1'b0;
      wr_vld = 1'b1;
      wr_dat = 80'(acc);
      @(negedge clk);
      if (afull && !afull_seen) begin
        afull_seen = 1'b1;
        chk("afull_rise_at_40", count, 40);
      end
      if (wr_rdy) acc++;
    end
    tick();
    chk("fill_accepted", acc, 51);
    chk("fill_wr_rdy", wr_rdy, 0);
    chk("fill_count", count, 51);
    chk("fill_afull", afull, 1);
    chk("fill_ovf", ovf, 1);
    chk("fill_afull_seen", afull_seen, 1);

    wr_vld = 1'b0; clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    chk("ovf_cleared", ovf, 0);
    wr_vld = 1'b1; clr_ovf = 1'b1;
    tick();
    wr_vld = 1'b0; clr_ovf = 1'b0;
    chk("ovf_set_wins", ovf, 1);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    chk("ovf_cleared2", ovf, 0);
    drain(200);

    // Streaming: 200 words, one per cycle after the 4-cycle fill
    nw = 0; npop = 0; first = -1; last = -1;
    for (int c = 0; c < 400 && npop < 200; c++) begin
      tick();
      wr_vld = (nw < 200);
      wr_dat = 80'(nw);
      rd_rdy = 1'b1;
      @(negedge clk);
      if (wr_vld && wr_rdy) nw++;
      if (rd_vld && rd_rdy) begin
        if (npop == 0) first = c;
        last = c;
        npop++;
      end
    end
    chk("stream_pops", npop, 200);
    chk("stream_first_cycle", first, 4);
    chk("stream_last_cycle", last, 203);
    drain(50);

    // Random valid/ready traffic, 1000 words
    nw = 0;
    for (int c = 0; c < 20000 && nw < 1000; c++) begin
      tick();
      wr_vld = (nw < 1000) ? 1'($urandom_range(0, 1)) : 1'b0;
      wr_dat = {48'hC0DE, 32'(nw)};
      rd_rdy = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (wr_vld && wr_rdy) nw++;
    end
    chk("rand_accepted", nw, 1000);
    drain(2000);

    // Reset with 20 words stored and 2 reads in flight
    nw = 0;
    for (int c = 0; c < 100 && nw < 22; c++) begin
      tick();
      rd_rdy = 1'b0;
      wr_vld = 1'b1;
      wr_dat = 80'(1000 + nw);
      @(negedge clk);
      if (wr_vld && wr_rdy) nw++;
    end
    tick();
    wr_vld = 1'b0;
    repeat (5) tick();
    rd_rdy = 1'b1;
    tick();
    tick();
    rd_rdy = 1'b0;
    chk("pre_rst_count", count, 20);
    #2 rst_ = 1'b0;
    #1;
    chk("arst_wr_rdy", wr_rdy, 1);
    chk("arst_rd_vld", rd_vld, 0);
    chk("arst_rd_dat", rd_dat, 0);
    chk("arst_count", count, 0);
    chk("arst_afull", afull, 0);
    chk("arst_ovf", ovf, 0);
    chk("arst_ram_we", ram_we, 0);
    chk("arst_ram_re", ram_re, 0);
    tick();
    rst_ = 1'b1;
    tick();
    wr_vld = 1'b1;
    wr_dat = 80'hBEEF;
    rd_rdy = 1'b1;
    tick();
    wr_vld = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (rd_vld) begin
        got = 1'b1;
        chk("post_rst_first_word", rd_dat, 80'hBEEF);
      end
    end
    if (!got) chk("post_rst_timeout", 0, 1);
    drain(50);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
